// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer.
//   state_e            : controller states (IDLE, RUN, PAUSE, EXPIRED)
//   MAX_SECONDS_DEF    : default upper limit of the count (0-99 display)
//   SEC_W              : width of the seconds datapath
//   sat_seconds()      : clamp a loaded value to the upper limit
package countdown_timer_pkg;

  localparam int unsigned SEC_W           = 7;
  localparam int unsigned MAX_SECONDS_DEF = 99;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  function automatic logic [SEC_W-1:0] sat_seconds(input logic [SEC_W-1:0] v,
                                                   input int unsigned       lim);
    logic [31:0] lim_v;
    lim_v = lim;
    return ({25'd0, v} > lim_v) ? lim_v[SEC_W-1:0] : v;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command/status bundle of the countdown timer.
//   load_en/load_value : load a duration (seconds, binary)
//   start/pause/cancel : one-cycle command strobes
//   seconds            : remaining seconds
//   running/paused     : state flags
//   timeout            : one-cycle expiry pulse
// master = command source, slave = timer.
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  logic             load_en;
  logic [SEC_W-1:0] load_value;
  logic             start;
  logic             pause;
  logic             cancel;
  logic [SEC_W-1:0] seconds;
  logic             running;
  logic             paused;
  logic             timeout;

  modport master (
    output load_en, load_value, start, pause, cancel,
    input  seconds, running, paused, timeout
  );

  modport slave (
    input  load_en, load_value, start, pause, cancel,
    output seconds, running, paused, timeout
  );
endinterface

// File: rtl/countdown_timer_tick_divider.sv
// One-second prescaler.
//   clk, reset : clock / synchronous active-high reset
//   enable     : advance the count this cycle
//   clear      : force the count to 0 (wins over enable)
//   tick       : high in the cycle the count wraps from TICKS-1 to 0
// tick is combinational so the controller can decrement on the same edge
// the prescaler wraps.
module tick_divider #(
  parameter int unsigned TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int unsigned      W    = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0]     LAST = W'(TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown timer with load / start / pause / cancel.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high, overrides every strobe
//   bus   : countdown_timer_if.slave (commands in, seconds/flags/timeout out)
// Strobe priority is cancel > load_en > start > pause; only the highest
// asserted strobe is acted on, even if it is a no-op in the current state.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned MAX_SECONDS   = MAX_SECONDS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  state_e           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [SEC_W-1:0] reload_q, reload_d;
  logic             tmo_q, tmo_d;
  logic             running_q, paused_q;

  logic             div_en, div_clr, tick;
  logic             cmd_load, cmd_start, cmd_pause;
  logic             idle_like;

  // Effective (winning) commands after priority resolution.
  assign cmd_load  = !bus.cancel && bus.load_en;
  assign cmd_start = !bus.cancel && !bus.load_en && bus.start;
  assign cmd_pause = !bus.cancel && !bus.load_en && !bus.start && bus.pause;
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_EXPIRED);

  // Counting continues in RUN unless cancelled or paused; load/start are
  // no-ops there and do not stall the prescaler.
  assign div_en  = (state_q == ST_RUN) && !bus.cancel && !cmd_pause;
  assign div_clr = bus.cancel || (cmd_start && idle_like);

  tick_divider #(.TICKS(TICKS_PER_SEC)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (div_en),
    .clear  (div_clr),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    secs_d   = secs_q;
    reload_d = reload_q;
    tmo_d    = 1'b0;

    if (bus.cancel) begin
      state_d = ST_IDLE;
      secs_d  = reload_q;
    end else if (cmd_load) begin
      if (idle_like) begin
        reload_d = sat_seconds(bus.load_value, MAX_SECONDS);
        secs_d   = sat_seconds(bus.load_value, MAX_SECONDS);
        state_d  = ST_IDLE;
      end
    end else if (cmd_start) begin
      unique case (state_q)
        ST_IDLE: begin
          if (secs_q != '0) state_d = ST_RUN;
          else              tmo_d   = 1'b1;
        end
        ST_EXPIRED: begin
          secs_d = reload_q;
          if (reload_q != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            tmo_d   = 1'b1;
          end
        end
        ST_PAUSE: state_d = ST_RUN;
        default:  ;
      endcase
    end else if (cmd_pause) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end

    // One-second decrement; RUN always holds a non-zero count.
    if (div_en && tick) begin
      secs_d = secs_q - SEC_W'(1);
      if (secs_q == SEC_W'(1)) begin
        state_d = ST_EXPIRED;
        tmo_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      secs_q    <= '0;
      reload_q  <= '0;
      tmo_q     <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      reload_q  <= reload_d;
      tmo_q     <= tmo_d;
      running_q <= (state_d == ST_RUN);
      paused_q  <= (state_d == ST_PAUSE);
    end
  end

  assign bus.seconds = secs_q;
  assign bus.running = running_q;
  assign bus.paused  = paused_q;
  assign bus.timeout = tmo_q;

endmodule
